// File: rtl/tap_pkg.sv
// Shared TAP definitions: FSM state encoding, opcodes, IR defaults, TDO source select.
package tap_pkg;

  localparam int         IR_WIDTH_DEF   = 4;
  localparam logic [3:0] IR_CAPTURE_DEF = 4'b0101;

  localparam logic [3:0] OP_EXTEST   = 4'h0;
  localparam logic [3:0] OP_SAMPLE   = 4'h1;
  localparam logic [3:0] OP_IDCODE   = 4'h2;
  localparam logic [3:0] OP_USERCODE = 4'h3;
  localparam logic [3:0] OP_INTEST   = 4'h4;
  localparam logic [3:0] OP_RUNBIST  = 4'h5;
  localparam logic [3:0] OP_CLAMP    = 4'h6;
  localparam logic [3:0] OP_HIGHZ    = 4'h7;
  localparam logic [3:0] OP_BYPASS   = 4'hF;

  // Classic 1149.1 encoding so STATE matches common logic-analyser decoders.
  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_t;

  typedef enum logic [1:0] {
    TDO_SEL_IR  = 2'd0,
    TDO_SEL_BYP = 2'd1,
    TDO_SEL_DR  = 2'd2
  } tdo_sel_t;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP FSM stepped by TMS on posedge TCK; state is registered, no backpressure.
// Synchronous active-low reset parks the machine in TLR regardless of TMS.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       TCK,
  input  logic       rst,
  input  logic       TMS,
  output tap_state_t state
);

  tap_state_t state_nxt;

  always_ff @(posedge TCK) begin
    if (!rst) state <= TLR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:     state_nxt = TMS ? TLR    : RTI;
      RTI:     state_nxt = TMS ? SEL_DR : RTI;
      SEL_DR:  state_nxt = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_nxt = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_nxt = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = TMS ? SEL_DR : RTI;
      SEL_IR:  state_nxt = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_nxt = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_nxt = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = TMS ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

endmodule

// File: rtl/tap_controller.sv
// TAP controller + IR/bypass: strobes decode state combinationally; TDO path re-registered on negedge TCK.
// No backpressure; optional STATE debug output enabled by define TAP_STATE_OUT_EN.
module tap_controller
  import tap_pkg::*;
#(
  parameter int                  IR_WIDTH   = IR_WIDTH_DEF,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_DEF)
) (
  input  logic       TCK,
  input  logic       rst,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       BSR_TDO,
  output logic       TDO,
  output logic       TDO_EN,
  output logic       SHIFTDR,
  output logic       CAPTUREDR,
  output logic       UPDATEDR,
  output logic       SHIFTIR,
  output logic       CAPTUREIR,
  output logic       UPDATEIR,
  output logic       TLRESET,
  output logic       BYPASS_SELECT,
  output logic       SAMPLE_SELECT,
  output logic       EXTEST_SELECT,
  output logic       INTEST_SELECT,
  output logic       RUNBIST_SELECT,
  output logic       CLAMP_SELECT,
  output logic       IDCODE_SELECT,
  output logic       USERCODE_SELECT,
  output logic       HIGHZ_SELECT
`ifdef TAP_STATE_OUT_EN
  ,
  output logic [3:0] STATE
`endif
);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass;
  logic                ir_tdo;
  logic                byp_tdo;
  tdo_sel_t            tdo_sel;

  tap_fsm u_fsm (
    .TCK   (TCK),
    .rst   (rst),
    .TMS   (TMS),
    .state (state)
  );

`ifdef TAP_STATE_OUT_EN
  assign STATE = state;
`endif

  assign SHIFTDR   = (state == SH_DR);
  assign CAPTUREDR = (state == CAP_DR);
  assign UPDATEDR  = (state == UPD_DR);
  assign SHIFTIR   = (state == SH_IR);
  assign CAPTUREIR = (state == CAP_IR);
  assign UPDATEIR  = (state == UPD_IR);
  assign TLRESET   = (state == TLR);

  // Unknown opcodes fall through to BYPASS so exactly one select is always live.
  always_comb begin
    BYPASS_SELECT   = 1'b0;
    SAMPLE_SELECT   = 1'b0;
    EXTEST_SELECT   = 1'b0;
    INTEST_SELECT   = 1'b0;
    RUNBIST_SELECT  = 1'b0;
    CLAMP_SELECT    = 1'b0;
    IDCODE_SELECT   = 1'b0;
    USERCODE_SELECT = 1'b0;
    HIGHZ_SELECT    = 1'b0;
    case (ir)
      IR_WIDTH'(OP_EXTEST):   EXTEST_SELECT   = 1'b1;
      IR_WIDTH'(OP_SAMPLE):   SAMPLE_SELECT   = 1'b1;
      IR_WIDTH'(OP_IDCODE):   IDCODE_SELECT   = 1'b1;
      IR_WIDTH'(OP_USERCODE): USERCODE_SELECT = 1'b1;
      IR_WIDTH'(OP_INTEST):   INTEST_SELECT   = 1'b1;
      IR_WIDTH'(OP_RUNBIST):  RUNBIST_SELECT  = 1'b1;
      IR_WIDTH'(OP_CLAMP):    CLAMP_SELECT    = 1'b1;
      IR_WIDTH'(OP_HIGHZ):    HIGHZ_SELECT    = 1'b1;
      IR_WIDTH'(OP_BYPASS):   BYPASS_SELECT   = 1'b1;
      default:                BYPASS_SELECT   = 1'b1;
    endcase
  end

  // A partial shift never reaches ir: only UPD_IR copies ir_shift across.
  always_ff @(posedge TCK) begin
    if (!rst) begin
      ir       <= IR_WIDTH'(OP_IDCODE);
      ir_shift <= '0;
      bypass   <= 1'b0;
    end else begin
      case (state)
        CAP_IR:  ir_shift <= IR_CAPTURE;
        SH_IR:   ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        UPD_IR:  ir       <= ir_shift;
        TLR:     ir       <= IR_WIDTH'(OP_IDCODE);
        CAP_DR:  if (BYPASS_SELECT) bypass <= 1'b0;
        SH_DR:   if (BYPASS_SELECT) bypass <= TDI;
        default: ;
      endcase
    end
  end

  // Falling-edge launch gives the receiver a full half-cycle of hold on TDO.
  always_ff @(negedge TCK) begin
    if (!rst) begin
      ir_tdo  <= 1'b0;
      byp_tdo <= 1'b0;
      TDO_EN  <= 1'b0;
      tdo_sel <= TDO_SEL_IR;
    end else begin
      ir_tdo  <= ir_shift[0];
      byp_tdo <= bypass;
      TDO_EN  <= (state == SH_IR) || (state == SH_DR);
      if (state == SH_IR)
        tdo_sel <= TDO_SEL_IR;
      else if ((state == SH_DR) && BYPASS_SELECT)
        tdo_sel <= TDO_SEL_BYP;
      else
        tdo_sel <= TDO_SEL_DR;
    end
  end

  always_comb begin
    TDO = 1'b0;
    if (TDO_EN) begin
      case (tdo_sel)
        TDO_SEL_IR:  TDO = ir_tdo;
        TDO_SEL_BYP: TDO = byp_tdo;
        default:     TDO = BSR_TDO;
      endcase
    end
  end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP controller and instruction register that sequences the JTAG data-register block.
- Runs the 16-state TAP FSM from TMS and produces SHIFTDR/CAPTUREDR/UPDATEDR for the DR block.
- Owns the instruction register, decodes it to the nine *_SELECT lines, and holds the 1-bit bypass register.
- Muxes IR, bypass or BSR_TDO onto TDO.

Parameters:
- IR_WIDTH, 4, instruction register width; opcodes are defined at this width.
- IR_CAPTURE, 4'b0101, value loaded into the IR shift stage in Capture-IR; LSBs must be 2'b01.

Ports:
- TCK  input  1  TAP clock; the only clock.
- rst  input  1  synchronous, active-low reset; sampled on posedge TCK.
- TMS  input  1  test mode select, sampled on posedge TCK.
- TDI  input  1  serial data in.
- BSR_TDO  input  1  serial out of the DR block; already registered on negedge.
- TDO  output  1  serial data out.
- TDO_EN  output  1  high while shifting IR or DR.
- SHIFTDR, CAPTUREDR, UPDATEDR  output  1 each  DR strobes.
- SHIFTIR, CAPTUREIR, UPDATEIR  output  1 each  IR strobes.
- TLRESET  output  1  FSM in Test-Logic-Reset.
- BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, RUNBIST_SELECT, CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT  output  1 each  one-hot instruction decode.

Behaviour:
- FSM:
  - States: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
  - Standard 1149.1 transitions on TMS at posedge TCK.
  - TMS=1 for 5 consecutive posedges reaches TLR from any state.
- Reset: rst=0 at posedge forces state=TLR, IR=IDCODE, ir_shift=0, bypass=0, tdo_sel=IR, TDO_EN=0. The FSM stays in TLR while rst=0, regardless of TMS.
- Strobes:
  - Each strobe is a pure decode of the state register: SHIFTDR=(state==SH_DR), CAPTUREDR=(state==CAP_DR), UPDATEDR=(state==UPD_DR), and the IR strobes likewise.
  - Strobes are high for every cycle spent in the state. The DR block acts on the same posedge.
- IR shift stage, on posedge:
  - CAP_IR: ir_shift<=IR_CAPTURE.
  - SH_IR: ir_shift<={TDI, ir_shift[IR_WIDTH-1:1]}, LSB first.
  - Other states: hold.
- IR update, on posedge:
  - UPD_IR: IR<=ir_shift; the new decode is valid from the next cycle.
  - TLR: IR<=IDCODE on every cycle.
- Decode:
  - EXTEST=0x0, SAMPLE=0x1, IDCODE=0x2, USERCODE=0x3, INTEST=0x4, RUNBIST=0x5, CLAMP=0x6, HIGHZ=0x7, BYPASS=0xF.
  - Any undefined opcode asserts BYPASS_SELECT.
  - Exactly one select is high at all times.
- Bypass, on posedge: in CAP_DR with BYPASS_SELECT, bypass<=0. In SH_DR with BYPASS_SELECT, bypass<=TDI.
- Output stage, on negedge TCK:
  - ir_tdo<=ir_shift[0]; byp_tdo<=bypass.
  - TDO_EN<=(state==SH_IR || state==SH_DR).
  - tdo_sel<=IR if SH_IR; BYP if SH_DR and BYPASS_SELECT; DR otherwise.
- TDO mux: TDO = TDO_EN ? mux(tdo_sel: ir_tdo / byp_tdo / BSR_TDO) : 0.
- Latency:
  - IR shift path: first TDO bit after entering SH_IR is IR_CAPTURE[0].
  - Bypass path: one TCK from TDI to TDO.
- Simultaneous events: rst=0 overrides TMS and all IR/DR activity on that edge.
- Reset or TLR mid-shift: a partial IR shift is discarded and the IR is never updated.

Optional Feature:
- Macro TAP_STATE_OUT_EN.
- Defined: adds output STATE[3:0] carrying the encoded FSM state, using the package encoding, for debug/LA. Reset value is the TLR encoding.
- Undefined: no STATE port and no extra logic; all other behaviour is identical.

Decomposition:
- Package tap_pkg:
  - Typedef for the state encoding (tap_state_t, 4-bit).
  - IR_WIDTH default.
  - Opcode constants OP_EXTEST..OP_BYPASS.
  - IR_CAPTURE default.
- Sub-module tap_fsm: TCK, rst, TMS -> state; pure next-state logic plus the state register. The top holds the IR, bypass, decode and TDO stage.

Test Plan:
- rst=0 for 2 TCKs, then rst=1 with TMS=0 -> state RTI, IDCODE_SELECT=1, all other selects 0, TDO_EN=0.
- From RTI, TMS 1,1,0,0 -> SH_IR. Shift 4 bits of TDI=0 with TMS=0,0,0,1 -> TDO bits in order 1,0,1,0 (IR_CAPTURE LSB first). TMS=1 then 0 -> UPD_IR passes; SAMPLE... EXTEST_SELECT=1 the cycle after UPD_IR.
- Load IR=0xF, enter SH_DR, drive TDI=1,0,1,1 -> CAPTURE bypass 0 appears first, then TDO=1,0,1,1 delayed one TCK.
- Load IR=0x9 (undefined) -> BYPASS_SELECT=1, others 0.
- In SH_DR with IDCODE, TMS=1 for 5 TCKs -> TLRESET=1, IR reads back IDCODE, UPDATEDR pulsed once on the exit path.
- rst=0 mid SH_IR after 2 bits -> next cycle state TLR, IR=IDCODE, TDO_EN=0 after the following negedge.
